// File: rtl/vga_pkg.sv
// vga_pkg: shared 640x480@60 timing constants, sync encodings and coordinate type.
package vga_pkg;
  localparam int DEF_CNT_W    = 10;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam logic SYNC_ACTIVE_LOW  = 1'b0;
  localparam logic SYNC_ACTIVE_HIGH = 1'b1;
  typedef logic [DEF_CNT_W-1:0] coord_t;
  function automatic int axis_total(input int a, input int f, input int s, input int b);
    return a + f + s + b;
  endfunction
  localparam int H_TOTAL = axis_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
  localparam int V_TOTAL = axis_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);
endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one raster axis; outputs load on en, count advances on adv.
module vga_axis_counter #(
  parameter int   ACTIVE   = 640,
  parameter int   FP       = 16,
  parameter int   SYNC     = 96,
  parameter int   BP       = 48,
  parameter logic SYNC_POL = 1'b0,
  parameter int   CNT_W    = 10
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             adv,
  output logic [CNT_W-1:0] cnt,
  output logic             wrap,
  output logic             act_nxt,
  output logic             sync
);
  localparam int TOTAL = ACTIVE + FP + SYNC + BP;
  localparam logic [CNT_W-1:0] LAST     = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] ACT_END  = CNT_W'(ACTIVE);
  localparam logic [CNT_W-1:0] SYNC_BEG = CNT_W'(ACTIVE + FP);
  localparam logic [CNT_W-1:0] SYNC_END = CNT_W'(ACTIVE + FP + SYNC - 1);
  logic [CNT_W-1:0] nxt;
  assign wrap    = adv && cnt == LAST;
  assign nxt     = wrap ? '0 : adv ? cnt + CNT_W'(1) : cnt;
  assign act_nxt = nxt < ACT_END;
  // outputs are derived from nxt so they line up with the new count
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt  <= '0;
      sync <= ~SYNC_POL;
    end else if (en) begin
      cnt  <= nxt;
      sync <= (nxt >= SYNC_BEG && nxt <= SYNC_END) ? SYNC_POL : ~SYNC_POL;
    end
  assert property (@(posedge clk) disable iff (!rst_n) cnt <= LAST);
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: single-clock raster timing with a divide-by-2 pixel strobe.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic SYNC_POL = SYNC_ACTIVE_LOW,
  parameter int   CNT_W    = DEF_CNT_W
)(
  input  logic             master_clk,
  input  logic             rst_n,
  output logic             pix_en,
  output logic [CNT_W-1:0] xCount,
  output logic [CNT_W-1:0] yCount,
  output logic             displayArea,
  output logic             blank_n,
  output logic             VGA_hSync,
  output logic             VGA_vSync,
  output logic             line_tick,
  output logic             frame_tick
);
  localparam int HT = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int VT = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  if (HT > 2**CNT_W || VT > 2**CNT_W) begin : g_width_chk
    $error("vga_timing_gen: H/V total does not fit in CNT_W bits");
  end
  logic primed, h_adv, h_wrap, v_wrap, h_act, v_act;
  assign h_adv = pix_en & primed;
  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .SYNC_POL(SYNC_POL), .CNT_W(CNT_W)
  ) u_h (
    .clk(master_clk), .rst_n(rst_n), .en(pix_en), .adv(h_adv),
    .cnt(xCount), .wrap(h_wrap), .act_nxt(h_act), .sync(VGA_hSync)
  );
  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .SYNC_POL(SYNC_POL), .CNT_W(CNT_W)
  ) u_v (
    .clk(master_clk), .rst_n(rst_n), .en(pix_en), .adv(h_wrap),
    .cnt(yCount), .wrap(v_wrap), .act_nxt(v_act), .sync(VGA_vSync)
  );
  // first strobe after reset only primes, so pixel (0,0) is shown rather than skipped
  always_ff @(posedge master_clk or negedge rst_n)
    if (!rst_n) begin
      pix_en      <= 1'b0;
      primed      <= 1'b0;
      displayArea <= 1'b0;
      blank_n     <= 1'b0;
      line_tick   <= 1'b0;
      frame_tick  <= 1'b0;
    end else begin
      pix_en     <= ~pix_en;
      line_tick  <= h_wrap;
      frame_tick <= v_wrap;
      if (pix_en) begin
        primed      <= 1'b1;
        displayArea <= h_act & v_act;
        blank_n     <= h_act & v_act;
      end
    end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench; default build for line timing, small SYNC_POL=1 build for frames.
module tb_vga_timing_gen;
  typedef struct packed {
    int         idx;
    logic [9:0] x;
    logic [9:0] y;
    logic       disp;
    logic       hs;
    logic       vs;
    logic       lt;
    logic       ft;
  } pix_t;

  logic clk = 1'b0;
  always #10 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rst0, rst1;
  logic pe0, da0, bn0, hs0, vs0, lt0, ft0;
  logic pe1, da1, bn1, hs1, vs1, lt1, ft1;
  logic [9:0] x0, y0, x1, y1;

  vga_timing_gen dut0 (
    .master_clk(clk), .rst_n(rst0), .pix_en(pe0), .xCount(x0), .yCount(y0),
    .displayArea(da0), .blank_n(bn0), .VGA_hSync(hs0), .VGA_vSync(vs0),
    .line_tick(lt0), .frame_tick(ft0)
  );
  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b1), .CNT_W(10)
  ) dut1 (
    .master_clk(clk), .rst_n(rst1), .pix_en(pe1), .xCount(x1), .yCount(y1),
    .displayArea(da1), .blank_n(bn1), .VGA_hSync(hs1), .VGA_vSync(vs1),
    .line_tick(lt1), .frame_tick(ft1)
  );

  int checks = 0, errors = 0;
  pix_t q0[$], q1[$];
  int idx0 = -1, idx1 = -1;

  function automatic pix_t px(int i, int x, int y, bit d, bit hs, bit vs, bit lt, bit ft);
    return '{idx: i, x: 10'(x), y: 10'(y), disp: d, hs: hs, vs: vs, lt: lt, ft: ft};
  endfunction

  function automatic void check(string tag, pix_t e, pix_t o, logic bn);
    checks++;
    if (o !== e || bn !== e.disp) begin
      errors++;
      $display("FAIL %s px%0d got x=%0d y=%0d da=%b bn=%b hs=%b vs=%b lt=%b ft=%b want x=%0d y=%0d da=%b hs=%b vs=%b lt=%b ft=%b",
               tag, e.idx, o.x, o.y, o.disp, bn, o.hs, o.vs, o.lt, o.ft, e.x, e.y, e.disp, e.hs, e.vs, e.lt, e.ft);
    end
  endfunction

  function automatic void chk(string n, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", n, got, want);
    end
  endfunction

  // monitor for the default build: pops expectations on each pixel update
  logic en0_q = 1'b0, lt0_q = 1'b0;
  int   lt0_last = -1;
  always @(negedge clk) begin
    if (!rst0) begin
      idx0 = -1;
      en0_q = 1'b0;
      lt0_q = 1'b0;
    end else begin
      if (en0_q) begin
        idx0++;
        if (q0.size() > 0 && q0[0].idx == idx0)
          check("d0", q0.pop_front(), px(idx0, x0, y0, da0, hs0, vs0, lt0, ft0), bn0);
      end
      if (lt0_q) chk("d0_lt_width", 32'(lt0), 32'd0);
      if (lt0 && !lt0_q) begin
        if (lt0_last >= 0) chk("d0_line_period", cyc - lt0_last, 32'd1600);
        lt0_last = cyc;
      end
      lt0_q = lt0;
      en0_q = pe0;
    end
  end

  // monitor for the small build; also counts frame ticks since reset release
  logic en1_q = 1'b0;
  int   ft1_cnt = 0;
  always @(negedge clk) begin
    if (!rst1) begin
      idx1 = -1;
      en1_q = 1'b0;
      ft1_cnt = 0;
    end else begin
      if (en1_q) begin
        idx1++;
        if (q1.size() > 0 && q1[0].idx == idx1)
          check("d1", q1.pop_front(), px(idx1, x1, y1, da1, hs1, vs1, lt1, ft1), bn1);
        if (idx1 == 159) chk("d1_no_early_ft", ft1_cnt, 32'd0);
      end
      if (ft1) ft1_cnt++;
      en1_q = pe1;
    end
  end

  task automatic wait_idx(input int which, input int target, input int budget);
    int n = 0;
    while ((which == 0 ? idx0 : idx1) < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      errors++;
      $display("FAIL timeout d%0d waiting for px%0d", which, target);
    end
  endtask

  initial begin
    rst0 = 1'b1;
    rst1 = 1'b1;
    #2;
    rst0 = 1'b0;
    rst1 = 1'b0;
    repeat (3) @(negedge clk);
    chk("d0_reset", {pe0, x0, y0, da0, bn0, hs0, vs0, lt0, ft0},
        {1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
    chk("d1_reset", {pe1, x1, y1, da1, bn1, hs1, vs1, lt1, ft1},
        {1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    q0.push_back(px(0,    0,   0, 1, 1, 1, 0, 0));
    q0.push_back(px(1,    1,   0, 1, 1, 1, 0, 0));
    q0.push_back(px(639,  639, 0, 1, 1, 1, 0, 0));
    q0.push_back(px(640,  640, 0, 0, 1, 1, 0, 0));
    q0.push_back(px(655,  655, 0, 0, 1, 1, 0, 0));
    q0.push_back(px(656,  656, 0, 0, 0, 1, 0, 0));
    q0.push_back(px(751,  751, 0, 0, 0, 1, 0, 0));
    q0.push_back(px(752,  752, 0, 0, 1, 1, 0, 0));
    q0.push_back(px(799,  799, 0, 0, 1, 1, 0, 0));
    q0.push_back(px(800,  0,   1, 1, 1, 1, 1, 0));
    q0.push_back(px(1600, 0,   2, 1, 1, 1, 1, 0));
    q0.push_back(px(1601, 1,   2, 1, 1, 1, 0, 0));
    #5 rst0 = 1'b1;
    #1 chk("d0_pe_first", 32'(pe0), 32'd0);
    @(negedge clk);
    chk("d0_pe_second", 32'(pe0), 32'd1);
    wait_idx(0, 1601, 4000);

    q1.push_back(px(0,  0,  0, 1, 0, 0, 0, 0));
    q1.push_back(px(10, 10, 0, 0, 1, 0, 0, 0));
    q1.push_back(px(12, 12, 0, 0, 1, 0, 0, 0));
    q1.push_back(px(13, 13, 0, 0, 0, 0, 0, 0));
    q1.push_back(px(16, 0,  1, 1, 0, 0, 1, 0));
    q1.push_back(px(53, 5,  3, 1, 0, 0, 0, 0));
    @(negedge clk);
    #5 rst1 = 1'b1;
    wait_idx(1, 53, 200);
    #3 rst1 = 1'b0;
    #1 chk("d1_async_reset", {pe1, x1, y1, da1, bn1, hs1, vs1, lt1, ft1},
           {1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    q1.push_back(px(0,   0,  0, 1, 0, 0, 0, 0));
    q1.push_back(px(1,   1,  0, 1, 0, 0, 0, 0));
    q1.push_back(px(111, 15, 6, 0, 0, 0, 0, 0));
    q1.push_back(px(117, 5,  7, 0, 0, 1, 0, 0));
    q1.push_back(px(128, 0,  8, 0, 0, 1, 1, 0));
    q1.push_back(px(144, 0,  9, 0, 0, 0, 1, 0));
    q1.push_back(px(159, 15, 9, 0, 0, 0, 0, 0));
    q1.push_back(px(160, 0,  0, 1, 0, 0, 1, 1));
    q1.push_back(px(161, 1,  0, 1, 0, 0, 0, 0));
    repeat (3) @(negedge clk);
    #5 rst1 = 1'b1;
    wait_idx(1, 161, 500);
    @(negedge clk);
    chk("d0_queue_drained", q0.size(), 32'd0);
    chk("d1_queue_drained", q1.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Raster timing generator for the 640x480@60 Hz display path. Runs on the 50 MHz master clock with an internal divide-by-2 pixel enable.
- Produces the pixel coordinates, sync pulses, display-area and blank_n strobes consumed by the snake top level, plus line/frame ticks for the game-update logic.
- Sits directly upstream of the pixel-colour stage; replaces the separate clock-divider/VGA-controller pair with one single-clock block.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, sync active level (0 = active-low)
- CNT_W, 10, coordinate counter width

Ports:
- master_clk  in  1  50 MHz system clock; the only clock
- rst_n  in  1  reset, asynchronous assert, active-low
- pix_en  out  1  one-cycle pixel strobe, every 2nd master_clk; also drives DAC_clk
- xCount  out  CNT_W  horizontal position, 0..H_TOTAL-1
- yCount  out  CNT_W  vertical position, 0..V_TOTAL-1
- displayArea  out  1  high when xCount < H_ACTIVE and yCount < V_ACTIVE
- blank_n  out  1  equal to displayArea; low during porches and sync
- VGA_hSync  out  1  horizontal sync, level per SYNC_POL
- VGA_vSync  out  1  vertical sync, level per SYNC_POL
- line_tick  out  1  one master_clk pulse when a line wraps
- frame_tick  out  1  one master_clk pulse when a frame wraps

Behaviour:
- Derived constants:
  - H_TOTAL = sum of H_*, 800 by default.
  - V_TOTAL = sum of V_*, 525 by default.
- Reset (rst_n low, asynchronous):
  - pix_en=0, xCount=0, yCount=0, displayArea=0, blank_n=0, line_tick=0, frame_tick=0, primed=0.
  - VGA_hSync and VGA_vSync are at their inactive level (~SYNC_POL).
- pix_en: a toggle flop that is 0 on reset release, giving the pattern 0,1,0,1... from the first clock after release.
- First pix_en after reset (primed=0):
  - Counters stay at (0,0); all outputs load the values for (0,0), so displayArea=1.
  - primed is set to 1 and no ticks are generated.
  - This way pixel (0,0) of the first frame is never skipped.
- Each later pix_en:
  - If xCount=H_TOTAL-1, xCount goes to 0; otherwise xCount increments.
  - On an x wrap: yCount increments, or goes to 0 if yCount=V_TOTAL-1.
  - No other cycles change the counters.
- Output alignment:
  - All outputs are registered and computed from the next counter values.
  - In the master_clk cycle after a pix_en edge, xCount, yCount, syncs, displayArea and blank_n all describe the same pixel, so latency is zero skew between coordinates and strobes.
  - Outputs hold for the full 2-cycle pixel period.
- Sync windows (checked on the new counter value):
  - VGA_hSync is active for x in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. [656,751].
  - VGA_vSync is active for y in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], i.e. [490,491].
  - Outside these windows both are inactive.
- Ticks:
  - line_tick is high for exactly one master_clk, in the same cycle the outputs show x=0 after a wrap.
  - frame_tick is high in the same cycle the outputs show (0,0) after the (H_TOTAL-1, V_TOTAL-1) wrap.
  - At a frame wrap both ticks are high together.
- Periods: one line = 1600 master_clk cycles; one frame = 840,000 cycles.
- Reset mid-frame: everything returns to the reset values immediately, with no completion of the current line. The first pix_en after release re-primes at (0,0).
- Counters never exceed TOTAL-1. Assert this in simulation.
- An elaboration-time error is required if H_TOTAL or V_TOTAL exceeds 2^CNT_W.

Decomposition:
- Shared package vga_pkg holds:
  - the 640x480 default timing constants and the H_TOTAL/V_TOTAL derivation;
  - the SYNC_ACTIVE_LOW/HIGH encodings;
  - a coord_t typedef of CNT_W bits.
- One natural sub-module, vga_axis_counter: a parameterised (ACTIVE, FP, SYNC, BP) counter with enable input, wrap output, and registered active/sync outputs. It is instantiated twice:
  - horizontal axis, enabled by pix_en;
  - vertical axis, enabled by pix_en & h_wrap.

Test Plan:
- Reset release -> pix_en low on the 1st clock and high on the 2nd; after the 2nd clock (0,0) with displayArea=1, blank_n=1, both syncs high, no ticks.
- Run one line -> xCount reaches 799 then 0 with line_tick=1 for exactly 1 cycle; 1600 master_clk cycles between consecutive line_ticks; yCount 0 to 1.
- Horizontal sync scan -> VGA_hSync low exactly for x=656..751 (96 pixels = 192 clocks); displayArea drops at x=640 and returns at x=0.
- Full frame -> VGA_vSync low only for y=490..491; frame_tick and line_tick coincide at (524,799) to (0,0); frame period 840,000 clocks.
- Assert rst_n low at (x=300, y=200) for 3 clocks, asynchronously mid-cycle -> outputs reset without waiting for a clock edge; after release, the first displayed pixel is (0,0) and there is no frame_tick until the next full frame.
- SYNC_POL=1 build -> sync windows identical with inverted levels; inactive level after reset is 0.
